// File: rtl/bmc_decoder.sv
// Biphase-mark decoder: turns two 12-symbol BMC half-cell blocks into one 24-bit data word.
// A data bit is 1 when the two half-cells of a symbol differ. Cell boundaries are not checked.
module bmc_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_block,
  input  logic        valid_in,
  output logic [23:0] o_block,
  output logic        valid_out
);

  // state      | meaning
  // PH_FIRST   | waiting for the first block of a pair
  // PH_SECOND  | first half-word held, waiting for the second block
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t      phase;
  logic [11:0] held;
  logic [11:0] decoded;

  // Symbol k is {i_block[2k+1], i_block[2k]}; a mid-cell transition decodes to 1.
  always_comb begin
    decoded = '0;
    for (int k = 0; k < 12; k++) begin
      decoded[k] = i_block[2*k+1] ^ i_block[2*k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PH_FIRST;
      held      <= '0;
      o_block   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        case (phase)
          PH_FIRST: begin
            held  <= decoded;
            phase <= PH_SECOND;
          end
          PH_SECOND: begin
            o_block   <= {held, decoded};
            valid_out <= 1'b1;
            phase     <= PH_FIRST;
          end
          default: phase <= PH_FIRST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmc_decoder.sv
// Bench for bmc_decoder: queue-based reference model checked every cycle, plus directed
// literal expectations for the documented scenarios and randomized traffic with resets.
module tb_bmc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] i_block;
  logic        valid_in;
  logic [23:0] o_block;
  logic        valid_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bmc_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .i_block   (i_block),
    .valid_in  (valid_in),
    .o_block   (o_block),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  // Reference model: accepted blocks are decoded into a queue; every second entry completes a word.
  logic [11:0] halves[$];
  logic [23:0] m_out   = '0;
  logic        m_valid = 1'b0;
  bit          m_known = 1'b0;

  function automatic logic [11:0] dec(input logic [23:0] b);
    logic [11:0] r;
    int unsigned sym;
    r = '0;
    for (int k = 0; k < 12; k++) begin
      sym = (int'(b) >> (2 * k)) & 3;
      r[k] = (sym == 1 || sym == 2);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      halves.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_valid = 1'b0;
      if (valid_in) begin
        halves.push_back(dec(i_block));
        if (halves.size() == 2) begin
          m_out   = {halves[0], halves[1]};
          m_valid = 1'b1;
          halves.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      check("cyc_valid_out", {23'd0, valid_out}, {23'd0, m_valid});
      check("cyc_o_block", o_block, m_out);
    end
  end

  // Literal expectations pin both the DUT and the model.
  task automatic lit(input string name, input logic ev, input logic [23:0] eb);
    check({name, "_valid"}, {23'd0, valid_out}, {23'd0, ev});
    check({name, "_block"}, o_block, eb);
    check({name, "_model_valid"}, {23'd0, m_valid}, {23'd0, ev});
    check({name, "_model_block"}, m_out, eb);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [23:0] b);
    rst      = r;
    valid_in = v;
    i_block  = b;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    i_block  = 24'($urandom);
  endtask

  task automatic send(input logic [23:0] b);
    cycle(1'b0, 1'b1, b);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 24'($urandom));
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    i_block  = '0;
    @(posedge clk);
    #1;
    do_reset();
    lit("reset", 1'b0, 24'h000000);

    // Basic pair
    send(24'hAAAAAA);
    lit("p1_first", 1'b0, 24'h000000);
    send(24'hCCCCCC);
    lit("p1_pulse", 1'b1, 24'hFFF000);
    idle();
    lit("p1_hold", 1'b0, 24'hFFF000);

    // Mixed symbols
    do_reset();
    send(24'hB4B4B4);
    send(24'h333333);
    lit("p2_pulse", 1'b1, 24'hAAA000);
    idle();
    lit("p2_hold", 1'b0, 24'hAAA000);

    // Gap between halves
    do_reset();
    send(24'h555555);
    for (int i = 0; i < 5; i++) begin
      idle();
      lit("gap_idle", 1'b0, 24'h000000);
    end
    send(24'hB4B4B4);
    lit("gap_pulse", 1'b1, 24'hFFFAAA);

    // Reset mid-pair drops the held half
    do_reset();
    send(24'hAAAAAA);
    do_reset();
    lit("midrst", 1'b0, 24'h000000);
    send(24'h333333);
    lit("midrst_first", 1'b0, 24'h000000);
    send(24'hAAAAAA);
    lit("midrst_pulse", 1'b1, 24'h000FFF);

    // Full rate
    do_reset();
    send(24'hAAAAAA);
    send(24'hCCCCCC);
    lit("b2b_pulse1", 1'b1, 24'hFFF000);
    send(24'hB4B4B4);
    lit("b2b_between", 1'b0, 24'hFFF000);
    send(24'h555555);
    lit("b2b_pulse2", 1'b1, 24'hAAAFFF);

    // Reset coincident with a second block
    do_reset();
    send(24'hAAAAAA);
    cycle(1'b1, 1'b1, 24'hCCCCCC);
    lit("rst_win", 1'b0, 24'h000000);
    send(24'hAAAAAA);
    lit("rst_win_next", 1'b0, 24'h000000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), 24'($urandom));
    end
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
